div_reconstruct: RTL



---
 rtl/div_reconstruct.sv | 125 ++++++++++++
 1 files changed

// File: rtl/div_reconstruct.sv
// div_reconstruct: sequential shift-and-add multiply-accumulate that rebuilds
// a dividend from divider outputs, dividend = quotient * divisor + remainder.
// One start pulse launches an operation; RUN always takes exactly WIDTH cycles,
// followed by one DONE cycle. The result register and a one-cycle done pulse
// update on the edge that leaves DONE.
//
// Optional build macro DIV_RECONSTRUCT_CHECK_EN adds an `expected` input that
// is latched at start and a `mismatch` flag refreshed on every completion.
module div_reconstruct #(
  parameter int WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     quotient,
  input  logic [WIDTH-1:0]     divisor,
  input  logic [WIDTH-1:0]     remainder,
`ifdef DIV_RECONSTRUCT_CHECK_EN
  input  logic [2*WIDTH-1:0]   expected,
  output logic                 mismatch,
`endif
  output logic [2*WIDTH-1:0]   dividend,
  output logic                 busy,
  output logic                 done
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [RW-1:0]    acc;
  logic [RW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_dec;

`ifdef DIV_RECONSTRUCT_CHECK_EN
  logic [RW-1:0]    expected_lat;
`endif

  assign count_dec = count - CW'(1);

  // State register: reset wins over any start in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: RUN exits once the step counter hits zero after its update.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (count_dec == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: busy covers RUN and DONE.
  always_comb begin
    busy = (state != IDLE);
  end

  // Datapath: operand latch, shift-and-add steps, result and done pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      count    <= '0;
      dividend <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc    <= {{WIDTH{1'b0}}, remainder};
            mcand  <= {{WIDTH{1'b0}}, divisor};
            mplier <= quotient;
            count  <= CW'(WIDTH);
          end
        end
        RUN: begin
          // No early exit on mplier == 0: the latency stays fixed at WIDTH.
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count_dec;
        end
        DONE: begin
          dividend <= acc;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef DIV_RECONSTRUCT_CHECK_EN
  // Self-check: compare the rebuilt dividend against the latched original.
  always_ff @(posedge clock) begin
    if (reset) begin
      expected_lat <= '0;
      mismatch     <= 1'b0;
    end else begin
      if (state == IDLE && start) expected_lat <= expected;
      if (state == DONE)          mismatch     <= (acc != expected_lat);
    end
  end
`endif

endmodule
